sba_rom_bridge: RTL and testbench

SBA_ROM_BRIDGE -- requirements
Module: sba_rom_bridge

---
 rtl/sba_rom_pkg.sv | 19 +
 rtl/addr_decode.sv | 33 +++
 rtl/sba_rom_bridge.sv | 199 +++++++++++++++++++
 tb/tb_sba_rom_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sba_rom_pkg.sv
// Shared types for the SBA-to-ROM bridge: address-map rule layout and the
// default two-ROM map.
package sba_rom_pkg;

    localparam int unsigned RuleAddrWidth = 64;

    typedef struct packed {
        logic [31:0]              idx;
        logic [RuleAddrWidth-1:0] start_addr;
        logic [RuleAddrWidth-1:0] end_addr;
    } addr_rule_t;

    // end_addr is exclusive (base + size)
    localparam addr_rule_t [1:0] DefaultRomRules = '{
        '{idx: 32'd1, start_addr: 64'h0000_0000_0001_0000, end_addr: 64'h0000_0000_0001_1000},
        '{idx: 32'd0, start_addr: 64'h0000_0000_0000_0000, end_addr: 64'h0000_0000_0000_4000}
    };

endpackage

// File: rtl/addr_decode.sv
// Address-map decoder: maps an address to the index of the rule whose
// [start_addr, end_addr) range contains it; the lowest rule index wins.
module addr_decode #(
    parameter int unsigned NoIndices = 2,
    parameter int unsigned NoRules   = 1,
    parameter type         addr_t    = logic,
    parameter type         rule_t    = logic,
    parameter int unsigned IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
    input  addr_t               addr_i,
    input  rule_t               addr_map_i [NoRules],
    output logic [IdxWidth-1:0] idx_o,
    output logic                dec_valid_o,
    output logic                dec_error_o,
    input  logic                en_default_idx_i,
    input  logic [IdxWidth-1:0] default_idx_i
);

    always_comb begin
        idx_o       = en_default_idx_i ? default_idx_i : '0;
        dec_valid_o = 1'b0;
        dec_error_o = ~en_default_idx_i;
        // Walk downwards so a lower-indexed match overrides a higher one
        for (int i = NoRules - 1; i >= 0; i--) begin
            if (addr_i >= addr_map_i[i].start_addr && addr_i < addr_map_i[i].end_addr) begin
                idx_o       = IdxWidth'(addr_map_i[i].idx);
                dec_valid_o = 1'b1;
                dec_error_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sba_rom_bridge.sv
// SBA slave that serves reads from narrow ROMs, one ROM word per enabled lane.
//   state | meaning
//   IDLE  | waiting for a request, grant is combinational
//   ISSUE | one-cycle rom_req for the lowest pending lane
//   WAIT  | counting down ROM latency, sample into lane on terminal count
//   RESP  | rvalid with assembled lanes, err=0
//   ERR   | rvalid with rdata=0 (write, decode miss or empty byte enables)
module sba_rom_bridge
    import sba_rom_pkg::*;
#(
    parameter int unsigned                BusWidth     = 64,
    parameter int unsigned                RomDataWidth = 32,
    parameter int unsigned                RomAddrWidth = 16,
    parameter int unsigned                NumRoms      = 2,
    parameter addr_rule_t [NumRoms-1:0]   RomRules     = DefaultRomRules,
    parameter int unsigned                RomLatency   = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  sba_req_i,
    input  logic                                  sba_we_i,
    input  logic [BusWidth-1:0]                   sba_addr_i,
    input  logic [BusWidth/8-1:0]                 sba_be_i,
    input  logic [BusWidth-1:0]                   sba_wdata_i,
    output logic                                  sba_gnt_o,
    output logic                                  sba_rvalid_o,
    output logic [BusWidth-1:0]                   sba_rdata_o,
    output logic                                  sba_err_o,
    output logic [NumRoms-1:0]                    rom_req_o,
    output logic [RomAddrWidth-1:0]               rom_addr_o,
    input  logic [NumRoms-1:0][RomDataWidth-1:0]  rom_rdata_i
);

    localparam int unsigned BeWidth    = BusWidth / 8;
    localparam int unsigned Ratio      = BusWidth / RomDataWidth;
    localparam int unsigned LaneBytes  = RomDataWidth / 8;
    localparam int unsigned OffShift   = $clog2(BeWidth);
    localparam int unsigned RatioShift = $clog2(Ratio);
    localparam int unsigned LaneW      = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int unsigned IdxW       = (NumRoms > 1) ? $clog2(NumRoms) : 1;
    localparam int unsigned CntW       = (RomLatency > 1) ? $clog2(RomLatency) : 1;

    if (BusWidth % RomDataWidth != 0) begin : g_err_width
        $error("BusWidth must be a multiple of RomDataWidth");
    end
    if (Ratio == 0 || (Ratio & (Ratio - 1)) != 0) begin : g_err_ratio
        $error("BusWidth/RomDataWidth must be a power of two");
    end
    if (RomLatency < 1) begin : g_err_lat
        $error("RomLatency must be at least 1");
    end
    for (genvar i = 0; i < NumRoms; i++) begin : g_chk_i
        for (genvar j = i + 1; j < NumRoms; j++) begin : g_chk_j
            if (RomRules[i].start_addr < RomRules[j].end_addr &&
                RomRules[j].start_addr < RomRules[i].end_addr) begin : g_err_ovl
                $error("RomRules entries overlap");
            end
        end
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_e;

    state_e                               state_q, state_d;
    logic [IdxW-1:0]                      hit_idx_q;
    logic [RomAddrWidth-1:0]              word_base_q;
    logic [RomAddrWidth-1:0]              rom_addr_q;
    logic [Ratio-1:0]                     lane_pend_q;
    logic [Ratio-1:0][RomDataWidth-1:0]   lane_buf_q;
    logic [CntW-1:0]                      cnt_q;
    logic                                 resp_err_q;

    addr_rule_t                           rom_map [NumRoms];
    logic [IdxW-1:0]                      dec_idx;
    logic                                 dec_valid, dec_error, dec_hit;
    logic [BusWidth-1:0]                  dec_base;
    logic [RomAddrWidth-1:0]              word_base_d;
    logic [Ratio-1:0]                     be_lanes;
    logic [LaneW-1:0]                     cur_lane;
    logic [RomAddrWidth-1:0]              rom_addr_calc;
    logic                                 grant;
    logic                                 unused_wdata;

    assign unused_wdata = ^sba_wdata_i;

    for (genvar g = 0; g < NumRoms; g++) begin : g_map
        assign rom_map[g] = RomRules[g];
    end

    addr_decode #(
        .NoIndices (NumRoms),
        .NoRules   (NumRoms),
        .addr_t    (logic [BusWidth-1:0]),
        .rule_t    (addr_rule_t)
    ) u_addr_decode (
        .addr_i           (sba_addr_i),
        .addr_map_i       (rom_map),
        .idx_o            (dec_idx),
        .dec_valid_o      (dec_valid),
        .dec_error_o      (dec_error),
        .en_default_idx_i (1'b0),
        .default_idx_i    ('0)
    );

    assign dec_hit = dec_valid & ~dec_error;

    always_comb begin
        dec_base = '0;
        for (int i = 0; i < NumRoms; i++) begin
            if (dec_idx == IdxW'(i)) dec_base = RomRules[i].start_addr[BusWidth-1:0];
        end
        for (int l = 0; l < Ratio; l++) begin
            be_lanes[l] = |sba_be_i[l*LaneBytes +: LaneBytes];
        end
        // Lowest pending lane is both the one being issued and the one sampled
        cur_lane = '0;
        for (int l = Ratio - 1; l >= 0; l--) begin
            if (lane_pend_q[l]) cur_lane = LaneW'(l);
        end
    end

    assign word_base_d   = RomAddrWidth'(((sba_addr_i - dec_base) >> OffShift) << RatioShift);
    assign rom_addr_calc = word_base_q + RomAddrWidth'(cur_lane);
    assign grant         = sba_req_i & (state_q == IDLE) & rst_ni;

    always_comb begin
        state_d      = state_q;
        sba_gnt_o    = grant;
        sba_rvalid_o = 1'b0;
        sba_err_o    = 1'b0;
        sba_rdata_o  = '0;
        rom_req_o    = '0;
        rom_addr_o   = rom_addr_q;
        unique case (state_q)
            IDLE: begin
                if (sba_req_i) begin
                    if (sba_we_i || !dec_hit || be_lanes == '0) state_d = ERR;
                    else                                        state_d = ISSUE;
                end
            end
            ISSUE: begin
                rom_req_o  = NumRoms'(1) << hit_idx_q;
                rom_addr_o = rom_addr_calc;
                state_d    = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if ((lane_pend_q & ~(Ratio'(1) << cur_lane)) != '0) state_d = ISSUE;
                    else                                                  state_d = RESP;
                end
            end
            RESP: begin
                sba_rvalid_o = 1'b1;
                sba_rdata_o  = lane_buf_q;
                state_d      = IDLE;
            end
            ERR: begin
                sba_rvalid_o = 1'b1;
                sba_err_o    = resp_err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hit_idx_q   <= '0;
            word_base_q <= '0;
            rom_addr_q  <= '0;
            lane_pend_q <= '0;
            lane_buf_q  <= '0;
            cnt_q       <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                hit_idx_q   <= dec_idx;
                word_base_q <= word_base_d;
                lane_pend_q <= be_lanes;
                lane_buf_q  <= '0;
                resp_err_q  <= sba_we_i | ~dec_hit;
            end
            if (state_q == ISSUE) begin
                cnt_q      <= CntW'(RomLatency - 1);
                rom_addr_q <= rom_addr_calc;
            end
            if (state_q == WAIT) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    lane_buf_q[cur_lane]  <= rom_rdata_i[hit_idx_q];
                    lane_pend_q[cur_lane] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sba_rom_bridge.sv
// Directed bench for sba_rom_bridge with a one-cycle-latency ROM model.
module tb_sba_rom_bridge;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req, we;
    logic [63:0]       addr, wdata;
    logic [7:0]        be;
    logic              gnt, rvalid, err;
    logic [63:0]       rdata;
    logic [1:0]        rom_req;
    logic [15:0]       rom_addr;
    logic [1:0][31:0]  rom_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [1:0] sel;
        logic [15:0] a;
    } rq_t;
    rq_t rq_log[$];

    sba_rom_bridge dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sba_req_i    (req),
        .sba_we_i     (we),
        .sba_addr_i   (addr),
        .sba_be_i     (be),
        .sba_wdata_i  (wdata),
        .sba_gnt_o    (gnt),
        .sba_rvalid_o (rvalid),
        .sba_rdata_o  (rdata),
        .sba_err_o    (err),
        .rom_req_o    (rom_req),
        .rom_addr_o   (rom_addr),
        .rom_rdata_i  (rom_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM data is valid only in the cycle after the strobe; otherwise garbage
    always @(posedge clk) begin
        rom_rdata[0] <= rom_req[0] ? 32'hA000_0000 + {16'h0, rom_addr} : 32'hDEAD_BEEF;
        rom_rdata[1] <= rom_req[1] ? 32'hB000_0000 + {16'h0, rom_addr} : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        #1;
        if (rom_req !== 2'b00) rq_log.push_back('{cyc, rom_req, rom_addr});
    end

    task automatic run_txn(input logic [63:0] a, input logic [7:0] b, input logic w,
                           output logic granted, output int g, output int lat,
                           output logic [63:0] rd, output logic er, output logic leak);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b;
        #1;
        granted = gnt;
        g = cyc;
        lat = -1; rd = '0; er = 1'b0; leak = 1'b0;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (rvalid === 1'b1) begin
                lat = k; rd = rdata; er = err;
                break;
            end
            if (rdata !== 64'h0 || err !== 1'b0) leak = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, rvalid, err, rdata, rom_req, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b err=%b rdata=%h rom_req=%b rom_addr=%h, want all 0",
                     gnt, rvalid, err, rdata, rom_req, rom_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rvalid, rom_req} !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: rvalid=%b rom_req=%b, want 0", rvalid, rom_req);
        end
    endtask

    task automatic test_read_full();
        logic granted, er, leak; int g, lat; logic [63:0] rd;
        rq_log.delete();
        run_txn(64'h8, 8'hFF, 1'b0, granted, g, lat, rd, er, leak);
        checks++; if (granted !== 1'b1) begin errors++; $display("FAIL full_gnt: got %b want 1", granted); end
        checks++; if (lat != 5) begin errors++; $display("FAIL full_latency: got %0d want 5", lat); end
        checks++; if (rd !== 64'hA000_0003_A000_0002) begin errors++; $display("FAIL full_rdata: got %h want a0000003a0000002", rd); end
        checks++; if (er !== 1'b0 || leak !== 1'b0) begin errors++; $display("FAIL full_err: err=%b leak=%b want 0 0", er, leak); end
        checks++;
        if (rq_log.size() != 2) begin
            errors++; $display("FAIL full_beats: got %0d rom_req cycles want 2", rq_log.size());
        end else begin
            if (rq_log[0].c - g != 1 || rq_log[0].sel !== 2'b01 || rq_log[0].a !== 16'd2) begin
                errors++;
                $display("FAIL full_beat0: cyc+%0d sel=%b addr=%0d want cyc+1 01 2", rq_log[0].c - g, rq_log[0].sel, rq_log[0].a);
            end
            checks++;
            if (rq_log[1].c - g != 3 || rq_log[1].sel !== 2'b01 || rq_log[1].a !== 16'd3) begin
                errors++;
                $display("FAIL full_beat1: cyc+%0d sel=%b addr=%0d want cyc+3 01 3", rq_log[1].c - g, rq_log[1].sel, rq_log[1].a);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rom_req !== 2'b00 || rom_addr !== 16'd3) begin
            errors++; $display("FAIL addr_hold: rom_req=%b rom_addr=%0d want 00 3", rom_req, rom_addr);
        end
    endtask

    task automatic test_read_upper();
        logic granted, er, leak; int g, lat; logic [63:0] rd;
        rq_log.delete();
        run_txn(64'h1_0004, 8'hF0, 1'b0, granted, g, lat, rd, er, leak);
        checks++; if (lat != 3) begin errors++; $display("FAIL upper_latency: got %0d want 3", lat); end
        checks++; if (rd !== 64'hB000_0001_0000_0000 || er !== 1'b0) begin errors++; $display("FAIL upper_rdata: got %h err=%b want b000000100000000 0", rd, er); end
        checks++;
        if (rq_log.size() != 1) begin
            errors++; $display("FAIL upper_beats: got %0d want 1", rq_log.size());
        end else if (rq_log[0].sel !== 2'b10 || rq_log[0].a !== 16'd1 || rq_log[0].c - g != 1) begin
            errors++; $display("FAIL upper_beat: sel=%b addr=%0d cyc+%0d want 10 1 cyc+1", rq_log[0].sel, rq_log[0].a, rq_log[0].c - g);
        end
    endtask

    task automatic test_errors();
        logic granted, er, leak; int g, lat; logic [63:0] rd;
        logic [63:0] a_tab [3] = '{64'h0, 64'h2_0000, 64'h0};
        logic [7:0]  b_tab [3] = '{8'hFF, 8'hFF, 8'h00};
        logic        w_tab [3] = '{1'b1, 1'b0, 1'b0};
        logic        e_tab [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            rq_log.delete();
            run_txn(a_tab[i], b_tab[i], w_tab[i], granted, g, lat, rd, er, leak);
            checks++;
            if (granted !== 1'b1 || lat != 1 || er !== e_tab[i] || rd !== 64'h0 || rq_log.size() != 0) begin
                errors++;
                $display("FAIL err_case%0d: gnt=%b lat=%0d err=%b rdata=%h romreqs=%0d want 1 1 %b 0 0",
                         i, granted, lat, er, rd, rq_log.size(), e_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gnt_c[$]; int rv_c[$]; logic [63:0] rv_d[$];
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 64'h0; be = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (gnt === 1'b1) gnt_c.push_back(cyc);
            if (rvalid === 1'b1) begin rv_c.push_back(cyc); rv_d.push_back(rdata); end
            @(negedge clk);
            if (gnt_c.size() == 2) req = 1'b0;
        end
        checks++;
        if (gnt_c.size() != 2 || rv_c.size() != 2) begin
            errors++; $display("FAIL b2b_counts: grants=%0d rvalids=%0d want 2 2", gnt_c.size(), rv_c.size());
        end else begin
            if (rv_c[0] - gnt_c[0] != 3 || gnt_c[1] - rv_c[0] != 1 || rv_c[1] - gnt_c[1] != 3) begin
                errors++;
                $display("FAIL b2b_timing: rv0=+%0d gnt1=rv0+%0d rv1=+%0d want 3 1 3",
                         rv_c[0] - gnt_c[0], gnt_c[1] - rv_c[0], rv_c[1] - gnt_c[1]);
            end
            checks++;
            if (rv_d[0] !== 64'h0000_0000_A000_0000 || rv_d[1] !== 64'h0000_0000_A000_0000) begin
                errors++; $display("FAIL b2b_rdata: got %h %h want 00000000a0000000 twice", rv_d[0], rv_d[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic granted, er, leak; int g, lat; logic [63:0] rd;
        logic seen;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 64'h8; be = 8'hFF;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({gnt, rvalid, err, rdata, rom_req, rom_addr} !== '0) begin
            errors++; $display("FAIL midreset_outputs: rvalid=%b rdata=%h rom_req=%b rom_addr=%h want 0", rvalid, rdata, rom_req, rom_addr);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if ({rvalid, err, rdata, rom_req} !== '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midreset_quiet: activity after release, want none"); end
        run_txn(64'h0, 8'hFF, 1'b0, granted, g, lat, rd, er, leak);
        checks++;
        if (granted !== 1'b1 || lat != 5 || rd !== 64'hA000_0001_A000_0000 || er !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fresh: gnt=%b lat=%0d rdata=%h err=%b want 1 5 a0000001a0000000 0", granted, lat, rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_read_full();
        test_read_upper();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
